avalon_mem_bridge: RTL and testbench

- Parametrised next-generation bridge between the Harvard CPU's instruction and data ports and a single Avalon-MM master interface.
- Replaces global clock-enable stalling with per-port req/ack handshakes.
- Arbitrates instruction and data traffic by a configurable priority.
- Generates byte lanes for sub-word stores and realigns and extends sub-word loads.
- Flags misaligned accesses and bus timeouts as errors instead of hanging.

---
 rtl/avalon_mem_bridge_if.sv | 50 +++++
 rtl/avalon_mem_bridge.sv | 222 ++++++++++++++++++++++
 tb/tb_avalon_mem_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_mem_bridge_if.sv
// Signal bundle between the Harvard CPU ports, the bridge and the Avalon-MM bus.
// The slave modport is the bridge's view; the master modport is the view of the
// environment that issues CPU requests and answers Avalon cycles.
interface avalon_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  // Instruction port
  logic              instr_req;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_ack;
  logic [31:0]       instr_rdata;
  logic              instr_err;
  // Data port
  logic              data_req;
  logic              data_we;
  logic [1:0]        data_size;
  logic              data_signed;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_ack;
  logic [31:0]       data_rdata;
  logic              data_err;
  logic              stall;
  // Avalon-MM master side
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [31:0]       av_writedata;
  logic [3:0]        av_byteenable;
  logic [31:0]       av_readdata;
  logic              av_waitrequest;

  modport slave (
    input  instr_req, instr_addr,
    output instr_ack, instr_rdata, instr_err,
    input  data_req, data_we, data_size, data_signed, data_addr, data_wdata,
    output data_ack, data_rdata, data_err, stall,
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_ack, instr_rdata, instr_err,
    output data_req, data_we, data_size, data_signed, data_addr, data_wdata,
    input  data_ack, data_rdata, data_err, stall,
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/avalon_mem_bridge.sv
// Bridge from the CPU instruction/data ports to one Avalon-MM master.
// Arbitrates the two ports, builds byte lanes for sub-word stores, aligns and
// extends sub-word loads, and turns misaligned accesses and bus timeouts into
// error acks. Optional single-entry fetch buffer: define AVB_IFETCH_BUFFER_EN.
module avalon_mem_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_mem_bridge_if.slave   bif
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_ACK} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] av_address_q;
  logic              av_read_q;
  logic              av_write_q;
  logic [31:0]       av_writedata_q;
  logic [3:0]        av_byteenable_q;
  logic              instr_ack_q, instr_err_q;
  logic [31:0]       instr_rdata_q;
  logic              data_ack_q, data_err_q;
  logic [31:0]       data_rdata_q;
  logic              sel_data_q;   // port served by the current transfer
  logic [1:0]        size_q;
  logic              sgn_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;

`ifdef AVB_IFETCH_BUFFER_EN
  logic              fb_valid_q;
  logic [ADDR_W-3:0] fb_addr_q;
  logic [31:0]       fb_data_q;
`endif

  // Request decode: arbitration, alignment legality and store lane generation
  logic        grant_data, grant_instr;
  logic [1:0]  d_off;
  logic        data_legal, instr_legal;
  logic [3:0]  st_be;
  logic [31:0] st_wd;

  always_comb begin
    grant_data  = bif.data_req && (!bif.instr_req || (DATA_PRIORITY != 0));
    grant_instr = bif.instr_req && !grant_data;
    d_off       = bif.data_addr[1:0];
    instr_legal = (bif.instr_addr[1:0] == 2'b00);
    case (bif.data_size)
      2'b00:   data_legal = (d_off == 2'b00);
      2'b01:   data_legal = !d_off[0];
      2'b10:   data_legal = 1'b1;
      default: data_legal = 1'b0;
    endcase
    st_be = 4'b1111;
    st_wd = bif.data_wdata;
    if (bif.data_size == 2'b01) begin
      // halfword copied into both halves; byteenable selects the live one
      st_be = d_off[1] ? 4'b1100 : 4'b0011;
      st_wd = {2{bif.data_wdata[15:0]}};
    end else if (bif.data_size == 2'b10) begin
      st_be = 4'b0001 << d_off;
      st_wd = {4{bif.data_wdata[7:0]}};
    end
  end

  // Move the addressed lane(s) down to bit 0 and extend to 32 bits
  function automatic logic [31:0] extend_load(input logic [31:0] rd, input logic [1:0] off,
                                              input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (size)
      2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
      2'b10:   return {{24{sgn & sh[7]}}, sh[7:0]};
      default: return sh;
    endcase
  endfunction

  // Main FSM with registered bus strobes, acks and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      av_address_q    <= '0;
      av_read_q       <= 1'b0;
      av_write_q      <= 1'b0;
      av_writedata_q  <= '0;
      av_byteenable_q <= 4'b1111;
      instr_ack_q     <= 1'b0;
      instr_err_q     <= 1'b0;
      instr_rdata_q   <= '0;
      data_ack_q      <= 1'b0;
      data_err_q      <= 1'b0;
      data_rdata_q    <= '0;
      sel_data_q      <= 1'b0;
      size_q          <= 2'b00;
      sgn_q           <= 1'b0;
      off_q           <= 2'b00;
      cnt_q           <= '0;
`ifdef AVB_IFETCH_BUFFER_EN
      fb_valid_q      <= 1'b0;
      fb_addr_q       <= '0;
      fb_data_q       <= '0;
`endif
    end else begin
      // acks and errors are single-cycle pulses
      instr_ack_q <= 1'b0;
      instr_err_q <= 1'b0;
      data_ack_q  <= 1'b0;
      data_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_data) begin
            sel_data_q <= 1'b1;
            size_q     <= bif.data_size;
            sgn_q      <= bif.data_signed;
            off_q      <= d_off;
            if (!data_legal) begin
              data_ack_q   <= 1'b1;
              data_err_q   <= 1'b1;
              data_rdata_q <= '0;
              state_q      <= S_ACK;
            end else begin
              av_address_q    <= {bif.data_addr[ADDR_W-1:2], 2'b00};
              av_read_q       <= !bif.data_we;
              av_write_q      <= bif.data_we;
              av_byteenable_q <= bif.data_we ? st_be : 4'b1111;
              av_writedata_q  <= st_wd;
              cnt_q           <= '0;
              state_q         <= S_BUS;
`ifdef AVB_IFETCH_BUFFER_EN
              // a store may overwrite the buffered instruction word
              if (bif.data_we && (fb_addr_q == bif.data_addr[ADDR_W-1:2]))
                fb_valid_q <= 1'b0;
`endif
            end
          end else if (grant_instr) begin
            sel_data_q <= 1'b0;
            if (!instr_legal) begin
              instr_ack_q   <= 1'b1;
              instr_err_q   <= 1'b1;
              instr_rdata_q <= '0;
              state_q       <= S_ACK;
`ifdef AVB_IFETCH_BUFFER_EN
            end else if (fb_valid_q && (fb_addr_q == bif.instr_addr[ADDR_W-1:2])) begin
              instr_ack_q   <= 1'b1;
              instr_rdata_q <= fb_data_q;
              state_q       <= S_ACK;
`endif
            end else begin
              av_address_q    <= {bif.instr_addr[ADDR_W-1:2], 2'b00};
              av_read_q       <= 1'b1;
              av_byteenable_q <= 4'b1111;
              cnt_q           <= '0;
              state_q         <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (!bif.av_waitrequest) begin
            av_read_q  <= 1'b0;
            av_write_q <= 1'b0;
            state_q    <= S_ACK;
            if (sel_data_q) begin
              data_ack_q   <= 1'b1;
              data_rdata_q <= extend_load(bif.av_readdata, off_q, size_q, sgn_q);
            end else begin
              instr_ack_q   <= 1'b1;
              instr_rdata_q <= bif.av_readdata;
`ifdef AVB_IFETCH_BUFFER_EN
              fb_valid_q    <= 1'b1;
              fb_addr_q     <= av_address_q[ADDR_W-1:2];
              fb_data_q     <= bif.av_readdata;
`endif
            end
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_MAX - 1'b1)) begin
            // abort: this edge would bring the wait count to the limit
            cnt_q      <= CNT_MAX;
            av_read_q  <= 1'b0;
            av_write_q <= 1'b0;
            state_q    <= S_ACK;
            if (sel_data_q) begin
              data_ack_q   <= 1'b1;
              data_err_q   <= 1'b1;
              data_rdata_q <= '0;
            end else begin
              instr_ack_q   <= 1'b1;
              instr_err_q   <= 1'b1;
              instr_rdata_q <= '0;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bif.av_address    = av_address_q;
  assign bif.av_read       = av_read_q;
  assign bif.av_write      = av_write_q;
  assign bif.av_writedata  = av_writedata_q;
  assign bif.av_byteenable = av_byteenable_q;
  assign bif.instr_ack     = instr_ack_q;
  assign bif.instr_err     = instr_err_q;
  assign bif.instr_rdata   = instr_rdata_q;
  assign bif.data_ack      = data_ack_q;
  assign bif.data_err      = data_err_q;
  assign bif.data_rdata    = data_rdata_q;
  assign bif.stall         = (bif.instr_req & ~instr_ack_q) | (bif.data_req & ~data_ack_q);

endmodule

// File: tb/tb_avalon_mem_bridge.sv
// Directed bench for avalon_mem_bridge: stimulus pushes expected bus cycles and
// acks into queues, a negedge monitor pops and compares them as they appear.
module tb_avalon_mem_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avalon_mem_bridge_if #(.ADDR_W(32)) bus ();

  avalon_mem_bridge #(
    .ADDR_W(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .bif(bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_cmp = 0;
  int    n_bad = 0;
  string tag = "reset";

  typedef struct {
    bit          port;   // 0 instr, 1 data
    logic [31:0] rdata;
    logic [31:0] rmask;
    bit          err;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] wmask;
    int          cyc;
  } bus_t;

  resp_t rq[$];
  bus_t  bq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL [%s] %s: got %h, expected %h", tag, nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL [%s] %s", tag, nm);
  endtask

  task automatic exp_resp(input bit port, input logic [31:0] rd, input logic [31:0] rm,
                          input bit err, input int c);
    resp_t e;
    e.port = port; e.rdata = rd; e.rmask = rm; e.err = err; e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic exp_bus(input bit we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] wm, input int c);
    bus_t e;
    e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.wmask = wm; e.cyc = c;
    bq.push_back(e);
  endtask

  task automatic check_bus();
    bus_t e;
    if (bq.size() == 0) begin
      fail_now($sformatf("unexpected bus cycle addr=%h", bus.av_address));
      return;
    end
    e = bq.pop_front();
    chk("bus_write", {31'd0, bus.av_write}, {31'd0, e.we});
    chk("bus_read", {31'd0, bus.av_read}, {31'd0, !e.we});
    chk("bus_addr", bus.av_address, e.addr);
    chk("bus_be", {28'd0, bus.av_byteenable}, {28'd0, e.be});
    if (e.we) chk("bus_wdata", bus.av_writedata & e.wmask, e.wdata & e.wmask);
    chk("bus_cycle", cyc, e.cyc);
  endtask

  task automatic check_resp(input bit port);
    resp_t e;
    if (rq.size() == 0) begin
      fail_now($sformatf("unexpected ack on port %0d", port));
      return;
    end
    e = rq.pop_front();
    chk("ack_port", {31'd0, port}, {31'd0, e.port});
    if (e.rmask != 0)
      chk("ack_rdata", (port ? bus.data_rdata : bus.instr_rdata) & e.rmask, e.rdata & e.rmask);
    chk("ack_err", {31'd0, port ? bus.data_err : bus.instr_err}, {31'd0, e.err});
    chk("ack_cycle", cyc, e.cyc);
  endtask

  // Monitor: compare each new bus cycle and each ack against the queues
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if ((bus.av_read || bus.av_write) && !prev_strobe) check_bus();
    prev_strobe <= bus.av_read || bus.av_write;
    if (bus.instr_ack) check_resp(1'b0);
    if (bus.data_ack)  check_resp(1'b1);
  end

  task automatic issue_instr(input logic [31:0] a, output int c0);
    @(negedge clk);
    bus.instr_req  = 1'b1;
    bus.instr_addr = a;
    c0 = cyc + 1;
  endtask

  task automatic issue_data(input bit we, input logic [1:0] sz, input bit sg,
                            input logic [31:0] a, input logic [31:0] wd, output int c0);
    @(negedge clk);
    bus.data_req    = 1'b1;
    bus.data_we     = we;
    bus.data_size   = sz;
    bus.data_signed = sg;
    bus.data_addr   = a;
    bus.data_wdata  = wd;
    c0 = cyc + 1;
  endtask

  task automatic wait_ack(input bit port);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port ? bus.data_ack : bus.instr_ack) begin
        seen = 1'b1;
        if (port) bus.data_req = 1'b0;
        else      bus.instr_req = 1'b0;
        break;
      end
    end
    if (!seen) begin
      fail_now($sformatf("no ack on port %0d within 40 cycles", port));
      bus.data_req  = 1'b0;
      bus.instr_req = 1'b0;
    end
  endtask

  // Simple word-store/word-load shorthands for the table-driven sub-word cases
  task automatic store_case(input string t, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] exp_wd, input logic [31:0] wm);
    int c0;
    tag = t;
    issue_data(1'b1, sz, 1'b0, a, wd, c0);
    exp_bus(1'b1, {a[31:2], 2'b00}, be, exp_wd, wm, c0);
    exp_resp(1'b1, 32'h0, 32'h0, 1'b0, c0 + 1);
    wait_ack(1'b1);
  endtask

  task automatic load_case(input string t, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp_rd);
    int c0;
    tag = t;
    bus.av_readdata = rd;
    issue_data(1'b0, sz, sg, a, 32'h0, c0);
    exp_bus(1'b0, {a[31:2], 2'b00}, 4'b1111, 32'h0, 32'h0, c0);
    exp_resp(1'b1, exp_rd, 32'hFFFF_FFFF, 1'b0, c0 + 1);
    wait_ack(1'b1);
  endtask

  task automatic bad_data_case(input string t, input logic [1:0] sz, input logic [31:0] a);
    int c0;
    tag = t;
    issue_data(1'b0, sz, 1'b0, a, 32'h0, c0);
    exp_resp(1'b1, 32'h0, 32'h0, 1'b1, c0);
    wait_ack(1'b1);
  endtask

  task automatic fetch_case(input string t, input logic [31:0] a, input logic [31:0] rd,
                            input bit via_bus);
    int c0;
    tag = t;
    bus.av_readdata = rd;
    issue_instr(a, c0);
    if (via_bus) begin
      exp_bus(1'b0, a, 4'b1111, 32'h0, 32'h0, c0);
      exp_resp(1'b0, rd, 32'hFFFF_FFFF, 1'b0, c0 + 1);
    end
    wait_ack(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset              = 1'b0;
    bus.instr_req      = 1'b0;
    bus.instr_addr     = '0;
    bus.data_req       = 1'b0;
    bus.data_we        = 1'b0;
    bus.data_size      = 2'b00;
    bus.data_signed    = 1'b0;
    bus.data_addr      = '0;
    bus.data_wdata     = '0;
    bus.av_readdata    = '0;
    bus.av_waitrequest = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_av_read", {31'd0, bus.av_read}, 32'd0);
    chk("rst_av_write", {31'd0, bus.av_write}, 32'd0);
    chk("rst_av_address", bus.av_address, 32'h0);
    chk("rst_av_be", {28'd0, bus.av_byteenable}, 32'hF);
    chk("rst_av_wdata", bus.av_writedata, 32'h0);
    chk("rst_acks", {30'd0, bus.instr_ack, bus.data_ack}, 32'd0);
    chk("rst_errs", {30'd0, bus.instr_err, bus.data_err}, 32'd0);
    chk("rst_instr_rdata", bus.instr_rdata, 32'h0);
    chk("rst_data_rdata", bus.data_rdata, 32'h0);
    reset = 1'b1;

    // Zero-wait fetch with stall check while the request is outstanding
    tag = "fetch0";
    bus.av_readdata = 32'h2402_000A;
    issue_instr(32'h100, c0);
    exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'h0, c0);
    exp_resp(1'b0, 32'h2402_000A, 32'hFFFF_FFFF, 1'b0, c0 + 1);
    #1 chk("stall_pending", {31'd0, bus.stall}, 32'd1);
    wait_ack(1'b0);

    // Simultaneous requests: data wins, fetch follows three cycles later
    tag = "simul";
    bus.av_readdata = 32'hCAFE_F00D;
    issue_data(1'b0, 2'b00, 1'b0, 32'h204, 32'h0, c0);
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h180;
    exp_bus(1'b0, 32'h204, 4'b1111, 32'h0, 32'h0, c0);
    exp_bus(1'b0, 32'h180, 4'b1111, 32'h0, 32'h0, c0 + 3);
    exp_resp(1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, c0 + 1);
    exp_resp(1'b0, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1'b0, c0 + 4);
    wait_ack(1'b1);
    wait_ack(1'b0);

    // Stores: byte lane replication, halfword placement, full word
    store_case("st_byte303", 2'b10, 32'h303, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'hFFFF_FFFF);
    store_case("st_byte300", 2'b10, 32'h300, 32'h0000_0055, 4'b0001, 32'h5555_5555, 32'hFFFF_FFFF);
    store_case("st_half302", 2'b01, 32'h302, 32'h0000_1234, 4'b1100, 32'h1234_0000, 32'hFFFF_0000);
    store_case("st_half300", 2'b01, 32'h300, 32'h0000_BEEF, 4'b0011, 32'h0000_BEEF, 32'h0000_FFFF);
    store_case("st_word400", 2'b00, 32'h400, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    // Loads: lane select and sign/zero extension
    load_case("ld_sbyte301", 2'b10, 1'b1, 32'h301, 32'h0000_F000, 32'hFFFF_FFF0);
    load_case("ld_ubyte301", 2'b10, 1'b0, 32'h301, 32'h0000_F000, 32'h0000_00F0);
    load_case("ld_ubyte303", 2'b10, 1'b0, 32'h303, 32'h7F00_0000, 32'h0000_007F);
    load_case("ld_shalf302", 2'b01, 1'b1, 32'h302, 32'h8001_0000, 32'hFFFF_8001);
    load_case("ld_uhalf300", 2'b01, 1'b0, 32'h300, 32'h1234_8765, 32'h0000_8765);

    // Misaligned / illegal requests: error ack in cycle 1, no bus cycle
    bad_data_case("bad_word102", 2'b00, 32'h102);
    bad_data_case("bad_half301", 2'b01, 32'h301);
    bad_data_case("bad_size11", 2'b11, 32'h400);
    tag = "bad_fetch101";
    issue_instr(32'h101, c0);
    exp_resp(1'b0, 32'h0, 32'h0, 1'b1, c0);
    wait_ack(1'b0);

    // One wait state adds one cycle
    tag = "wait1";
    bus.av_readdata    = 32'h1357_9BDF;
    bus.av_waitrequest = 1'b1;
    issue_data(1'b0, 2'b00, 1'b0, 32'h600, 32'h0, c0);
    exp_bus(1'b0, 32'h600, 4'b1111, 32'h0, 32'h0, c0);
    exp_resp(1'b1, 32'h1357_9BDF, 32'hFFFF_FFFF, 1'b0, c0 + 2);
    repeat (2) @(negedge clk);
    bus.av_waitrequest = 1'b0;
    wait_ack(1'b1);

    // Timeout with waitrequest stuck high (limit 4)
    tag = "timeout";
    bus.av_readdata    = 32'hFFFF_FFFF;
    bus.av_waitrequest = 1'b1;
    issue_data(1'b0, 2'b00, 1'b0, 32'h500, 32'h0, c0);
    exp_bus(1'b0, 32'h500, 4'b1111, 32'h0, 32'h0, c0);
    exp_resp(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, c0 + 4);
    wait_ack(1'b1);
    chk("timeout_strobe_low", {31'd0, bus.av_read}, 32'd0);
    bus.av_waitrequest = 1'b0;

    // Reset asserted while the read strobe is up: strobe drops at once, no ack
    tag = "reset_mid_bus";
    bus.av_waitrequest = 1'b1;
    issue_instr(32'h700, c0);
    exp_bus(1'b0, 32'h700, 4'b1111, 32'h0, 32'h0, c0);
    @(negedge clk);
    chk("read_before_reset", {31'd0, bus.av_read}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("read_after_reset", {31'd0, bus.av_read}, 32'd0);
    chk("be_after_reset", {28'd0, bus.av_byteenable}, 32'hF);
    @(negedge clk);
    reset              = 1'b1;
    bus.instr_req      = 1'b0;
    bus.av_waitrequest = 1'b0;
    repeat (4) @(negedge clk);

    // Repeated fetch of one word; a store to that word forces a fresh read
    fetch_case("refetch_a", 32'h100, 32'h2402_000A, 1'b1);
`ifdef AVB_IFETCH_BUFFER_EN
    tag = "refetch_hit";
    bus.av_readdata = 32'hFFFF_FFFF;
    issue_instr(32'h100, c0);
    exp_resp(1'b0, 32'h2402_000A, 32'hFFFF_FFFF, 1'b0, c0);
    wait_ack(1'b0);
`else
    fetch_case("refetch_b", 32'h100, 32'h2402_000B, 1'b1);
`endif
    store_case("st_word100", 2'b00, 32'h100, 32'h1111_1111, 4'b1111, 32'h1111_1111, 32'hFFFF_FFFF);
    fetch_case("fetch_after_store", 32'h100, 32'h0BAD_C0DE, 1'b1);

    repeat (5) @(negedge clk);
    tag = "drain";
    chk("resp_queue_empty", rq.size(), 32'd0);
    chk("bus_queue_empty", bq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
